// File: rtl/m68k_trace_sequencer.sv
// ---------------------------------------------------------------------------
// m68k_trace_sequencer
//
// Records completed 68000 bus cycles into a circular history buffer and
// selects which entry the bus-status text overlay shows. The shown entry is
// latched only at the frame boundary (x == 0, y == SCREEN_HEIGHT), so a frame
// never displays a torn value. A freeze level stops capture and enables
// browsing; each step pulse moves the view one entry older, wrapping back to
// the newest entry after the oldest valid one.
//
// Optional feature macro: TRACE_FILTER_EN
//   defined   : only cycles with FILTER_LO <= bus_addr <= FILTER_HI are kept
//   undefined : every valid cycle is kept; FILTER_LO/FILTER_HI are unused
//
// Ports:
//   clk          in   1                 system/pixel clock, rising edge
//   rst_n        in   1                 synchronous active-low reset
//   bus_addr     in   32                address of completed bus cycle
//   bus_data     in   16                data of completed bus cycle
//   bus_write    in   1                 1 = write, 0 = read
//   bus_valid    in   1                 one pulse per completed bus cycle
//   x, y         in   10                current scan column / line
//   freeze       in   1                 level: stop capture, browse history
//   step         in   1                 pulse: view one entry older (frozen)
//   disp_addr    out  32                overlay address (frame-latched)
//   disp_data    out  16                overlay data (frame-latched)
//   disp_write   out  1                 overlay direction (frame-latched)
//   disp_offset  out  $clog2(DEPTH)     age of shown entry, 0 = newest
//   hist_count   out  $clog2(DEPTH)+1   valid entries, saturates at DEPTH
//   cycle_total  out  16                captured-cycle counter, wraps
// ---------------------------------------------------------------------------
module m68k_trace_sequencer #(
    parameter int          DEPTH         = 16,
    parameter int          SCREEN_HEIGHT = 600,
    parameter logic [31:0] FILTER_LO     = 32'h0000_0000,
    parameter logic [31:0] FILTER_HI     = 32'hFFFF_FFFF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              bus_addr,
    input  logic [15:0]              bus_data,
    input  logic                     bus_write,
    input  logic                     bus_valid,
    input  logic [9:0]               x,
    input  logic [9:0]               y,
    input  logic                     freeze,
    input  logic                     step,
    output logic [31:0]              disp_addr,
    output logic [15:0]              disp_data,
    output logic                     disp_write,
    output logic [$clog2(DEPTH)-1:0] disp_offset,
    output logic [$clog2(DEPTH):0]   hist_count,
    output logic [15:0]              cycle_total
);

    localparam int           AW          = $clog2(DEPTH);
    localparam logic [AW:0]  CNT_FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]  CNT_ONE     = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [9:0]   STROBE_LINE = 10'(SCREEN_HEIGHT);

    typedef enum logic {
        LIVE   = 1'b0,
        FROZEN = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] data;
        logic        write;
    } entry_t;

    entry_t         hist_mem [DEPTH];
    state_t         state;
    logic [AW-1:0]  wp;
    logic [AW-1:0]  offset;

    logic           in_range;
    logic           capture;
    logic           strobe;
    logic [AW-1:0]  rd_idx;
    entry_t         rd_entry;
    logic [AW:0]    offset_inc;

`ifdef TRACE_FILTER_EN
    assign in_range = (bus_addr >= FILTER_LO) && (bus_addr <= FILTER_HI);
`else
    // Filter bounds are intentionally inert in this build.
    logic unused_filter_cfg;
    assign unused_filter_cfg = ^{FILTER_LO, FILTER_HI};
    assign in_range = 1'b1;
`endif

    // Capture is qualified by the registered state, so a freeze that rises
    // together with bus_valid still records that cycle.
    assign capture    = bus_valid && (state == LIVE) && in_range;
    assign strobe     = (x == '0) && (y == STROBE_LINE);

    // Power-of-two depth: pointer arithmetic wraps modulo DEPTH for free.
    assign rd_idx     = wp - PTR_ONE - offset;
    assign rd_entry   = hist_mem[rd_idx];
    assign offset_inc = {1'b0, offset} + CNT_ONE;

    // NOTE: the history RAM has no reset; its contents are only observable
    // once hist_count covers them, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (capture) begin
            hist_mem[wp] <= entry_t'({bus_addr, bus_data, bus_write});
        end
    end

    // NOTE: all state uses non-blocking assignments so every branch below
    // sees the pre-edge values of wp, offset and hist_count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= LIVE;
            wp          <= '0;
            offset      <= '0;
            hist_count  <= '0;
            cycle_total <= '0;
            disp_addr   <= '0;
            disp_data   <= '0;
            disp_write  <= 1'b0;
            disp_offset <= '0;
        end else begin
            if (capture) begin
                wp          <= wp + PTR_ONE;
                cycle_total <= cycle_total + 16'd1;
                if (hist_count != CNT_FULL) begin
                    hist_count <= hist_count + CNT_ONE;
                end
            end

            case (state)
                LIVE: begin
                    offset <= '0;
                    if (freeze) begin
                        state <= FROZEN;
                    end
                end
                FROZEN: begin
                    if (!freeze) begin
                        // Unfreeze wins over a coincident step.
                        state  <= LIVE;
                        offset <= '0;
                    end else if (step) begin
                        offset <= (offset_inc < hist_count) ? offset_inc[AW-1:0] : '0;
                    end
                end
                default: begin
                    state  <= LIVE;
                    offset <= '0;
                end
            endcase

            // Frame-synchronous load uses the pre-edge pointer and buffer, so
            // a capture in the strobe cycle shows up on the following frame.
            if (strobe) begin
                if (hist_count == '0) begin
                    disp_addr   <= '0;
                    disp_data   <= '0;
                    disp_write  <= 1'b0;
                    disp_offset <= '0;
                end else begin
                    disp_addr   <= rd_entry.addr;
                    disp_data   <= rd_entry.data;
                    disp_write  <= rd_entry.write;
                    disp_offset <= offset;
                end
            end
        end
    end

endmodule

// File: doc/m68k_trace_sequencer.md
# m68k_trace_sequencer

Capture and sequencing controller that sits between the 68000 bus-monitor taps and the on-screen bus-status text overlay. It records completed bus cycles into a circular history buffer and selects which entry the overlay shows. The selected entry's address, data and direction are presented to the overlay only at a frame boundary, so a frame never shows a torn value. A freeze/step control lets the operator stop capture and walk back through history.

## Interface
- DEPTH, 16: history entries; power of two, 2..256
- SCREEN_HEIGHT, 600: visible lines; frame boundary is line SCREEN_HEIGHT
- FILTER_LO, 32'h0000_0000: lowest captured address (used only with TRACE_FILTER_EN)
- FILTER_HI, 32'hFFFF_FFFF: highest captured address, inclusive (used only with TRACE_FILTER_EN)

Ports:
- clk  in  1  pixel/system clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- bus_addr  in  32  address of the completed bus cycle
- bus_data  in  16  data of the completed bus cycle
- bus_write  in  1  1 = write cycle, 0 = read cycle
- bus_valid  in  1  one-cycle pulse per completed bus cycle
- x  in  10  current scan column
- y  in  10  current scan line
- freeze  in  1  level; 1 = stop capture and enter browse mode
- step  in  1  one-cycle pulse; move view one entry older while frozen
- disp_addr  out  32  address shown on the overlay
- disp_data  out  16  data shown on the overlay
- disp_write  out  1  direction shown on the overlay
- disp_offset  out  $clog2(DEPTH)  age of the shown entry; 0 = newest
- hist_count  out  $clog2(DEPTH)+1  valid entries, saturating at DEPTH
- cycle_total  out  16  captured-cycle counter; wraps 16'hFFFF -> 0

## Operation
- Reset (rst_n low at an edge): all outputs 0; write pointer wp = 0; offset = 0; state = LIVE; buffer contents don't-care.
- Capture:
  - Condition is bus_valid && state == LIVE, using registered state.
  - Writes {addr, data, write} to buf[wp].
  - wp = (wp + 1) mod DEPTH.
  - hist_count = min(hist_count + 1, DEPTH).
  - cycle_total += 1.
- LIVE state:
  - offset held at 0.
  - step is ignored.
  - freeze == 1 -> FROZEN, offset = 0.
- FROZEN state:
  - No capture.
  - step -> offset = offset + 1 if offset + 1 < hist_count, else 0 (wraps to newest).
  - freeze == 0 -> LIVE, offset = 0. If step arrives in the same cycle, it is ignored.
- Read index: (wp − 1 − offset) mod DEPTH.
- Frame boundary strobe: x == 0 && y == SCREEN_HEIGHT (one cycle per frame).
  - On the strobe, disp_addr/disp_data/disp_write load buf[read index] and disp_offset loads offset.
  - If hist_count == 0, they load 0.
- Between strobes, disp_* hold their value regardless of capture, step or freeze.
- hist_count and cycle_total update immediately; they are not frame-synchronised.

## Timing
- Capture: entry written at the edge where bus_valid is high. hist_count and cycle_total are visible the following cycle.
- Display update: disp_* change at the edge ending the strobe cycle. Latency is 1 cycle from the strobe.
- Capture coinciding with the strobe: the read uses the pre-edge wp and buffer, so the new entry appears next frame.
- Freeze transitions:
  - freeze rising in the same cycle as bus_valid: the cycle is captured (state still LIVE); capture stops from the next cycle.
  - freeze falling: capture resumes the cycle after the state returns to LIVE.
- Buffer full: the oldest entry is overwritten and hist_count stays at DEPTH.
- Mid-operation reset: takes effect at the next edge and overrides all other events.

## Configuration
- TRACE_FILTER_EN defined: capture additionally requires FILTER_LO <= bus_addr <= FILTER_HI (unsigned). Out-of-range cycles do not touch the buffer, hist_count or cycle_total.
- TRACE_FILTER_EN undefined: every valid cycle is captured. FILTER_LO/FILTER_HI are ignored and generate no logic.

## Test plan
- Reset, then 3 captures (0x100/0x1111/w, 0x102/0x2222/r, 0x104/0x3333/w), then a strobe -> disp = 0x104/0x3333/1, disp_offset 0, hist_count 3, cycle_total 3.
- Freeze, 2 steps, strobe -> disp = 0x100/0x1111/1, offset 2. Third step + strobe -> wraps to offset 0 (0x104).
- DEPTH = 16, 20 captures with addr = i -> hist_count 16; newest shows addr 19; 15 steps -> addr 4; one more step -> addr 19.
- bus_valid every cycle while frozen, then unfreeze -> cycle_total unchanged during freeze; first capture after unfreeze shows as the new newest entry.
- Capture on the same cycle as the strobe -> disp still shows the previous newest; the next strobe shows the new entry.
- TRACE_FILTER_EN with FILTER_LO = 0x1000, FILTER_HI = 0x1FFF: captures at 0x0FFF, 0x1000, 0x2000 -> hist_count 1, disp_addr 0x1000.
